// File: rtl/voq_rd_sched_if.sv
// Bundle of VOQ status inputs, read-control outputs and returned-word tags
// shared between the switch core / output logic (master) and the output-side
// read scheduler (slave).
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 4
`endif

interface voq_rd_sched_if #(
    parameter int PORT_NUB  = `PORT_NUB_TOTAL,
    parameter int WIDTH_SEL = $clog2(PORT_NUB)
);
    logic                            sched_en;
    logic [PORT_NUB*PORT_NUB-1:0]    empty;
    logic [PORT_NUB-1:0]             out_ready;
    logic [PORT_NUB*WIDTH_SEL-1:0]   rd_sel;
    logic [PORT_NUB-1:0]             rd_en;
    logic [PORT_NUB-1:0]             data_valid;
    logic [PORT_NUB*WIDTH_SEL-1:0]   data_src;

    // Switch side: supplies queue status and readiness, consumes read controls.
    modport master (
        output sched_en,
        output empty,
        output out_ready,
        input  rd_sel,
        input  rd_en,
        input  data_valid,
        input  data_src
    );

    // Scheduler side.
    modport slave (
        input  sched_en,
        input  empty,
        input  out_ready,
        output rd_sel,
        output rd_en,
        output data_valid,
        output data_src
    );
endinterface

// File: rtl/voq_rd_sched.sv
// Output-side VOQ read scheduler. One round-robin arbiter per output port
// picks the next non-empty source queue to pop, gated by downstream readiness
// and the global enable. Returned words are tagged with valid/source one cycle
// after the pop strobe, matching the registered VOQ read.
//
// Optional feature macro: VOQ_RD_SCHED_CNT_EN adds cnt_clr and a saturating
// 16-bit per-output grant counter (grant_cnt).
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 4
`endif

module voq_rd_sched #(
    parameter int PORT_NUB  = `PORT_NUB_TOTAL,
    parameter int WIDTH_SEL = $clog2(PORT_NUB)
) (
    input  logic                   clk,
    input  logic                   rst_n,
`ifdef VOQ_RD_SCHED_CNT_EN
    input  logic                   cnt_clr,
    output logic [PORT_NUB*16-1:0] grant_cnt,
`endif
    voq_rd_sched_if.slave          bus
);

    // Per-output arbiter and pipeline state.
    logic [PORT_NUB-1:0][WIDTH_SEL-1:0] ptr_q, ptr_d;
    logic [PORT_NUB-1:0][WIDTH_SEL-1:0] rd_sel_q, rd_sel_d;
    logic [PORT_NUB-1:0]                rd_en_q, rd_en_d;
    logic [PORT_NUB-1:0]                data_valid_q, data_valid_d;
    logic [PORT_NUB-1:0][WIDTH_SEL-1:0] data_src_q, data_src_d;

    // Request vector per output after masking, and the arbiter result
    // {found, index} per output.
    logic [PORT_NUB-1:0][PORT_NUB-1:0]  elig;
    logic [PORT_NUB-1:0][WIDTH_SEL:0]   pick;

    // First set bit of req searched upward from start, wrapping naturally
    // through the WIDTH_SEL-bit index. Scanning from the far end and letting
    // nearer candidates overwrite keeps the loop free of early exits.
    function automatic logic [WIDTH_SEL:0] rr_pick(
        input logic [WIDTH_SEL-1:0] start,
        input logic [PORT_NUB-1:0]  req
    );
        logic [WIDTH_SEL:0]   res;
        logic [WIDTH_SEL-1:0] cand;
        res = '0;
        for (int k = PORT_NUB - 1; k >= 0; k--) begin
            cand = start + WIDTH_SEL'(k);
            if (req[cand]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

    // Eligibility: non-empty, downstream ready, enabled, and not the source
    // being popped right now (its empty flag has not caught up yet).
    always_comb begin
        elig = '0;
        for (int i = 0; i < PORT_NUB; i++) begin
            for (int s = 0; s < PORT_NUB; s++) begin
                elig[i][s] = ~bus.empty[i*PORT_NUB + s]
                           & bus.out_ready[i]
                           & bus.sched_en
                           & ~(rd_en_q[i] & (rd_sel_q[i] == WIDTH_SEL'(s)));
            end
        end
    end

    // Round-robin grant per output; pointer moves just past the winner.
    always_comb begin
        pick     = '0;
        rd_en_d  = '0;
        rd_sel_d = rd_sel_q;
        ptr_d    = ptr_q;
        for (int i = 0; i < PORT_NUB; i++) begin
            pick[i] = rr_pick(ptr_q[i], elig[i]);
            if (pick[i][WIDTH_SEL]) begin
                rd_en_d[i]  = 1'b1;
                rd_sel_d[i] = pick[i][WIDTH_SEL-1:0];
                ptr_d[i]    = pick[i][WIDTH_SEL-1:0] + 1'b1;
            end
        end
    end

    // Returned-word tags trail the pop strobe by one cycle.
    always_comb begin
        data_valid_d = rd_en_q;
        data_src_d   = rd_sel_q;
    end

    // Arbiter and pipeline registers; reset discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q        <= '0;
            rd_sel_q     <= '0;
            rd_en_q      <= '0;
            data_valid_q <= '0;
            data_src_q   <= '0;
        end else begin
            ptr_q        <= ptr_d;
            rd_sel_q     <= rd_sel_d;
            rd_en_q      <= rd_en_d;
            data_valid_q <= data_valid_d;
            data_src_q   <= data_src_d;
        end
    end

    assign bus.rd_en      = rd_en_q;
    assign bus.rd_sel     = rd_sel_q;
    assign bus.data_valid = data_valid_q;
    assign bus.data_src   = data_src_q;

`ifdef VOQ_RD_SCHED_CNT_EN
    logic [PORT_NUB-1:0][15:0] cnt_q, cnt_d;

    // Saturating pop counters; clear wins over a same-cycle increment.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < PORT_NUB; i++) begin
            if (cnt_clr) begin
                cnt_d[i] = '0;
            end else if (rd_en_q[i] && (cnt_q[i] != 16'hFFFF)) begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_voq_rd_sched.sv
// Bench for voq_rd_sched with PORT_NUB=4. A small VOQ depth model drives the
// empty flags (flag lags a pop by one cycle); every observed pop is pushed to
// a scoreboard and popped when the tagged word must appear a cycle later.
module tb_voq_rd_sched;
    localparam int N = 4;
    localparam int W = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    voq_rd_sched_if #(.PORT_NUB(N), .WIDTH_SEL(W)) bus_if ();

`ifdef VOQ_RD_SCHED_CNT_EN
    logic          cnt_clr;
    logic [N*16-1:0] grant_cnt;
`endif

    voq_rd_sched #(.PORT_NUB(N), .WIDTH_SEL(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef VOQ_RD_SCHED_CNT_EN
        .cnt_clr   (cnt_clr),
        .grant_cnt (grant_cnt),
`endif
        .bus       (bus_if)
    );

    typedef struct {
        int           port;
        logic [W-1:0] src;
    } sb_ent_t;

    sb_ent_t      sb_q[$];
    int           n_last;
    int           n_pass;
    int           n_total;
    int           depth [N][N];
    int           pop_cnt;
    logic [N-1:0] obs_en;
    logic [W-1:0] obs_sel [N];

    task automatic upd_empty();
        for (int i = 0; i < N; i++)
            for (int s = 0; s < N; s++)
                bus_if.empty[i*N + s] = (depth[i][s] == 0);
    endtask

    task automatic load(input int i, input int s, input int n);
        depth[i][s] = n;
        upd_empty();
    endtask

    // One clock cycle: sample at negedge, score returned words, record pops,
    // then apply pops to the depth model just after the rising edge.
    task automatic step();
        logic [N-1:0] hit;
        sb_ent_t      e;
        @(negedge clk);
        hit = '0;
        for (int k = 0; k < n_last; k++) begin
            e = sb_q.pop_front();
            hit[e.port] = 1'b1;
            n_total++;
            if (bus_if.data_valid[e.port] !== 1'b1 || bus_if.data_src[e.port*W +: W] !== e.src)
                $display("FAIL data_word port %0d: got valid=%b src=%0d, need valid=1 src=%0d",
                         e.port, bus_if.data_valid[e.port], bus_if.data_src[e.port*W +: W], e.src);
            else n_pass++;
        end
        n_total++;
        if ((bus_if.data_valid & ~hit) !== '0)
            $display("FAIL spurious_valid: got data_valid=%b, need only %b", bus_if.data_valid, hit);
        else n_pass++;
        obs_en = bus_if.rd_en;
        n_last = 0;
        for (int i = 0; i < N; i++) begin
            obs_sel[i] = bus_if.rd_sel[i*W +: W];
            if (obs_en[i] === 1'b1) begin
                n_total++;
                if (depth[i][obs_sel[i]] <= 0)
                    $display("FAIL pop_empty_voq port %0d src %0d: depth %0d, need >0",
                             i, obs_sel[i], depth[i][obs_sel[i]]);
                else n_pass++;
                e.port = i;
                e.src  = obs_sel[i];
                sb_q.push_back(e);
                n_last++;
                pop_cnt++;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (obs_en[i] === 1'b1 && depth[i][obs_sel[i]] > 0)
                depth[i][obs_sel[i]]--;
        upd_empty();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb_q.delete();
        n_last  = 0;
        pop_cnt = 0;
        for (int i = 0; i < N; i++)
            for (int s = 0; s < N; s++)
                depth[i][s] = 0;
        upd_empty();
        bus_if.sched_en  = 1'b1;
        bus_if.out_ready = '1;
`ifdef VOQ_RD_SCHED_CNT_EN
        cnt_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_total++;
        if (bus_if.rd_en !== '0 || bus_if.rd_sel !== '0 || bus_if.data_valid !== '0 || bus_if.data_src !== '0)
            $display("FAIL reset_state: got rd_en=%b rd_sel=%h dv=%b src=%h, need all 0",
                     bus_if.rd_en, bus_if.rd_sel, bus_if.data_valid, bus_if.data_src);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_all_empty();
        do_reset();
        for (int c = 0; c < 20; c++) begin
            step();
            n_total++;
            if (obs_en !== '0) $display("FAIL idle_rd_en cycle %0d: got %b, need 0000", c, obs_en);
            else n_pass++;
        end
        for (int s = 0; s < N; s++) load(0, s, 4);
        step();
        step();
        n_total++;
        if (obs_en[0] !== 1'b1 || obs_sel[0] !== 2'd0)
            $display("FAIL idle_first_grant: got en=%b sel=%0d, need en=1 sel=0", obs_en[0], obs_sel[0]);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [W-1:0] exp_q[$];
        logic [W-1:0] ev;
        do_reset();
        for (int s = 0; s < N; s++) load(0, s, 8);
        for (int k = 0; k < 8; k++) begin
            ev = W'(k % N);
            exp_q.push_back(ev);
        end
        step();
        n_total++;
        if (obs_en !== '0) $display("FAIL rr_latency: got rd_en=%b, need 0000", obs_en);
        else n_pass++;
        while (exp_q.size() > 0) begin
            step();
            ev = exp_q.pop_front();
            n_total++;
            if (obs_en !== 4'b0001 || obs_sel[0] !== ev)
                $display("FAIL rr_seq: got rd_en=%b sel=%0d, need rd_en=0001 sel=%0d", obs_en, obs_sel[0], ev);
            else n_pass++;
        end
        step();
    endtask

    task automatic test_single_source();
        logic [9:0] pat;
        pat = 10'b0000101010;
        do_reset();
        load(2, 1, 3);
        for (int c = 0; c < 10; c++) begin
            step();
            n_total++;
            if (obs_en !== {1'b0, pat[c], 2'b00} || (obs_en[2] === 1'b1 && obs_sel[2] !== 2'd1))
                $display("FAIL single_src cycle %0d: got rd_en=%b sel=%0d, need rd_en=%b sel=1",
                         c, obs_en, obs_sel[2], {1'b0, pat[c], 2'b00});
            else n_pass++;
        end
        n_total++;
        if (pop_cnt !== 3) $display("FAIL single_src_pops: got %0d, need 3", pop_cnt);
        else n_pass++;
    endtask

    task automatic test_out_ready();
        logic [14:0]  en_pat;
        logic [W-1:0] sel_tab [15];
        en_pat  = 15'b111100000111110;
        sel_tab = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
                    2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        for (int s = 0; s < N; s++) load(1, s, 10);
        for (int c = 0; c < 15; c++) begin
            bus_if.out_ready[1] = !(c >= 5 && c <= 9);
            step();
            n_total++;
            if (obs_en[1] !== en_pat[c] || obs_sel[1] !== sel_tab[c])
                $display("FAIL out_ready cycle %0d: got en=%b sel=%0d, need en=%b sel=%0d",
                         c, obs_en[1], obs_sel[1], en_pat[c], sel_tab[c]);
            else n_pass++;
        end
        step();
    endtask

    task automatic test_reset_mid();
        int budget;
        do_reset();
        for (int s = 0; s < N; s++) load(3, s, 6);
        budget = 10;
        do begin
            step();
            budget--;
        end while (obs_en[3] !== 1'b1 && budget > 0);
        n_total++;
        if (obs_en[3] !== 1'b1) $display("FAIL reset_mid_wait: got rd_en[3]=%b, need 1 within 10 cycles", obs_en[3]);
        else n_pass++;
        n_total++;
        if (bus_if.rd_en[3] !== 1'b1) $display("FAIL reset_mid_pre: got rd_en[3]=%b, need 1", bus_if.rd_en[3]);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (bus_if.rd_en !== '0 || bus_if.rd_sel !== '0 || bus_if.data_valid !== '0 || bus_if.data_src !== '0)
            $display("FAIL reset_mid_clear: got rd_en=%b rd_sel=%h dv=%b src=%h, need all 0",
                     bus_if.rd_en, bus_if.rd_sel, bus_if.data_valid, bus_if.data_src);
        else n_pass++;
        do_reset();
        for (int s = 0; s < N; s++) load(3, s, 6);
        step();
        step();
        n_total++;
        if (obs_en !== 4'b1000 || obs_sel[3] !== 2'd0)
            $display("FAIL reset_mid_restart: got rd_en=%b sel=%0d, need rd_en=1000 sel=0", obs_en, obs_sel[3]);
        else n_pass++;
        repeat (3) step();
    endtask

    task automatic test_all_ports();
        logic [N-1:0] en_tab  [4];
        logic [W-1:0] sel_tab [4][N];
        en_tab  = '{4'b1111, 4'b1011, 4'b1111, 4'b1011};
        sel_tab = '{'{2'd0, 2'd2, 2'd1, 2'd0}, '{2'd1, 2'd3, 2'd1, 2'd3},
                    '{2'd0, 2'd2, 2'd1, 2'd0}, '{2'd1, 2'd3, 2'd1, 2'd3}};
        do_reset();
        load(0, 0, 4); load(0, 1, 4);
        load(1, 2, 4); load(1, 3, 4);
        load(2, 1, 2);
        load(3, 0, 4); load(3, 3, 4);
        step();
        for (int k = 0; k < 4; k++) begin
            step();
            n_total++;
            if (obs_en !== en_tab[k]) $display("FAIL all_ports_en k=%0d: got %b, need %b", k, obs_en, en_tab[k]);
            else n_pass++;
            for (int p = 0; p < N; p++) begin
                n_total++;
                if (obs_sel[p] !== sel_tab[k][p])
                    $display("FAIL all_ports_sel k=%0d port %0d: got %0d, need %0d", k, p, obs_sel[p], sel_tab[k][p]);
                else n_pass++;
            end
        end
        repeat (6) step();
    endtask

    task automatic test_sched_en();
        do_reset();
        for (int s = 0; s < N; s++) load(0, s, 6);
        step();
        step();
        bus_if.sched_en = 1'b0;
        step();
        n_total++;
        if (obs_en[0] !== 1'b1 || obs_sel[0] !== 2'd1)
            $display("FAIL sched_en_inflight: got en=%b sel=%0d, need en=1 sel=1", obs_en[0], obs_sel[0]);
        else n_pass++;
        for (int c = 0; c < 4; c++) begin
            step();
            n_total++;
            if (obs_en !== '0) $display("FAIL sched_en_off cycle %0d: got %b, need 0000", c, obs_en);
            else n_pass++;
        end
        bus_if.sched_en = 1'b1;
        step();
        step();
        n_total++;
        if (obs_en[0] !== 1'b1 || obs_sel[0] !== 2'd2)
            $display("FAIL sched_en_resume: got en=%b sel=%0d, need en=1 sel=2", obs_en[0], obs_sel[0]);
        else n_pass++;
        step();
    endtask

`ifdef VOQ_RD_SCHED_CNT_EN
    task automatic test_counter();
        int budget;
        do_reset();
        load(0, 0, 40000);
        load(0, 1, 40000);
        budget = 70100;
        while (pop_cnt < 70000 && budget > 0) begin
            step();
            budget--;
            if (pop_cnt == 1000 && obs_en[0] === 1'b1) begin
                n_total++;
                if (grant_cnt[15:0] !== 16'd1000) $display("FAIL cnt_1000: got %0d, need 1000", grant_cnt[15:0]);
                else n_pass++;
            end
        end
        n_total++;
        if (pop_cnt < 70000) $display("FAIL cnt_budget: got %0d pops, need 70000", pop_cnt);
        else n_pass++;
        n_total++;
        if (grant_cnt[15:0] !== 16'hFFFF) $display("FAIL cnt_saturate: got %h, need ffff", grant_cnt[15:0]);
        else n_pass++;
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        n_total++;
        if (obs_en[0] !== 1'b1 || grant_cnt[15:0] !== 16'd0)
            $display("FAIL cnt_clr: got en=%b cnt=%0d, need en=1 cnt=0", obs_en[0], grant_cnt[15:0]);
        else n_pass++;
        step();
        n_total++;
        if (grant_cnt[15:0] !== {15'd0, obs_en[0]})
            $display("FAIL cnt_after_clr: got %0d, need %0d", grant_cnt[15:0], obs_en[0]);
        else n_pass++;
    endtask
`endif

    initial begin
        n_pass  = 0;
        n_total = 0;
        n_last  = 0;
        pop_cnt = 0;
        rst_n   = 1'b0;
        bus_if.sched_en  = 1'b0;
        bus_if.out_ready = '0;
        bus_if.empty     = '1;
`ifdef VOQ_RD_SCHED_CNT_EN
        cnt_clr = 1'b0;
`endif
        @(posedge clk);
        #1;
        test_reset();
        test_all_empty();
        test_round_robin();
        test_single_source();
        test_out_ready();
        test_reset_mid();
        test_all_ports();
        test_sched_en();
`ifdef VOQ_RD_SCHED_CNT_EN
        test_counter();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/voq_rd_sched.md
# voq_rd_sched

Output-side read scheduler for the shared-memory switch. Watches the per-output, per-source empty flags of the second-stage VOQs and drives the per-output read-select and read-enable. One independent round-robin arbiter per output port chooses which source queue to pop each cycle, gated by downstream readiness. Sits between the switch core and the output port logic, and tags each returned data word with valid and source.

## Interface
Parameters:
- PORT_NUB, default `PORT_NUB_TOTAL: number of ports; must be a power of two and at least 2.
- WIDTH_SEL, default $clog2(PORT_NUB): source index width.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- sched_en  input  1  global enable; 0 stops new reads only.
- empty  input  PORT_NUB*PORT_NUB  VOQ empty flags; bit [i*PORT_NUB+s] = output i, source s is empty.
- out_ready  input  PORT_NUB  output i can accept one word 2 cycles after sampling.
- rd_sel  output  PORT_NUB*WIDTH_SEL  registered source select per output, to the switch rd_sel.
- rd_en  output  PORT_NUB  registered pop strobe per output, to the switch rd_en.
- data_valid  output  PORT_NUB  switch port_out slice i is valid this cycle.
- data_src  output  PORT_NUB*WIDTH_SEL  source index of the valid word.

## Operation
- Per output i: rotating priority pointer ptr[i] (WIDTH_SEL bits), reset 0.
- Eligible source s: empty[i*PORT_NUB+s]==0, and not masked, and out_ready[i]==1, and sched_en==1.
- Mask: a source whose rd_en is high this cycle is ineligible this cycle. The VOQ empty flag lags a pop by one cycle, so this mask prevents a double pop of a single-entry queue.
- Grant: the first eligible s searched from ptr[i] upward, modulo PORT_NUB (wrap-around).
- On grant:
  - rd_en[i] <= 1 and rd_sel[i] <= s at the next edge.
  - ptr[i] <= s+1 (mod PORT_NUB, natural wrap of WIDTH_SEL bits).
- No grant: rd_en[i] <= 0, rd_sel[i] holds, ptr[i] holds.
- data_valid[i] <= rd_en[i] and data_src[i] <= rd_sel[i]. This is a one-cycle pipeline matching the VOQ registered read.
- Output ports are fully independent. Any number of ports may issue in the same cycle.
- Throughput:
  - One word/cycle per output when at least 2 of its sources are non-empty.
  - One word every 2 cycles when only one source is non-empty.

## Timing
- Decision in cycle t uses empty, out_ready and sched_en of cycle t. rd_en/rd_sel are registered and valid in t+1. data_valid/data_src are valid in t+2, aligned with switch port_out.
- out_ready low in cycle t means no pop is issued for t+1. The downstream must absorb any word already in flight, at most 2.
- sched_en deassert: issued reads complete normally, and data_valid still follows. No new rd_en from the next edge.
- Reset, including mid-operation: rd_en=0, rd_sel=0, data_valid=0, data_src=0, ptr=0, asynchronously. In-flight words are discarded.
- All empty flags high: rd_en stays 0 indefinitely and ptr is frozen.

## Configuration
- VOQ_RD_SCHED_CNT_EN defined:
  - Adds input cnt_clr (1 bit, synchronous).
  - Adds output grant_cnt (PORT_NUB*16 bits).
  - Per output, a 16-bit counter increments on each rd_en, saturates at 16'hFFFF, and is cleared by cnt_clr or reset.
  - cnt_clr takes priority over an increment in the same cycle.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- PORT_NUB=4, output 0 with sources 0..3 all non-empty and out_ready=1:
  - rd_sel[0] sequence is 0,1,2,3,0 on consecutive cycles with rd_en steady 1.
  - data_src follows 2 cycles behind the decision.
- Output 2, only source 1 non-empty, holding 3 words: rd_en[2] pulses every other cycle, with exactly 3 pops and no pop after the empty flag rises.
- out_ready[1]=0 for cycles 5..9 with data queued: no rd_en[1] from cycle 6 through 10, then resumes at the correct pointer position.
- Reset asserted while rd_en[3]=1: all outputs are 0 immediately. After release, the first grant starts the search from source 0.
- All four outputs loaded simultaneously with disjoint source patterns: independent grants occur on the same cycle with no cross-port interference.
- With VOQ_RD_SCHED_CNT_EN:
  - 70000 pops on output 0 leave grant_cnt[0]=16'hFFFF.
  - cnt_clr together with rd_en gives 0 on the next edge.
